// File: rtl/gray_counter_pkg.sv
// Shared constants and helpers for the Gray-code counter slice.
package gray_counter_pkg;

    // Default counter / code width.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Widest code this slice supports.
    localparam int unsigned MAX_WIDTH = 16;

    // Binary to reflected Gray code. Operates at MAX_WIDTH. Narrower
    // callers zero-extend the input and truncate the result.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_btg.sv
// Purely combinational binary-to-Gray encoder. This is the mirror of gtb.
module btg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of a binary bit and its next-higher
    // neighbour. The MSB passes through unchanged.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down binary counter with a Gray-coded copy and a wrap
// pulse. bin, gray and wrap all come straight from flops, so gray can
// cross clock domains as a pointer.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    // Next-state mux with priority load > count > hold, plus wrap detect.
    always_comb begin
        bin_next  = bin;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                bin_next  = bin + ONE;
                wrap_next = (bin == '1);
            end else begin
                bin_next  = bin - ONE;
                wrap_next = (bin == '0);
            end
        end
    end

    // Encode the next value ahead of the register, so gray stays glitch-free.
    btg #(.WIDTH(WIDTH)) u_btg (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // State registers. bin and gray load from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=4: directed vector table,
// hand-written reset sequences, then random stimulus against a model.
module tb_gray_counter;
    import gray_counter_pkg::*;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int vectors;
    int miscompares;

    // Reference state: a plain integer count and a reflected-code table.
    int unsigned m_cnt;
    bit          m_wrap;
    int unsigned gtab[MOD];

    typedef struct {
        bit           ld;
        bit           e;
        bit           u;
        logic [W-1:0] lb;
        logic [W-1:0] xbin;
        logic [W-1:0] xgray;
        bit           xwrap;
    } vec_t;

    vec_t tbl[$];

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_step();
        if (load) begin
            m_cnt  = int'(load_bin);
            m_wrap = 1'b0;
        end else if (en && up) begin
            m_wrap = (m_cnt == MOD - 1);
            m_cnt  = (m_cnt + 1) % MOD;
        end else if (en) begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MOD - 1) % MOD;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit ld, input bit e, input bit u, input logic [W-1:0] lb);
        load     = ld;
        en       = e;
        up       = u;
        load_bin = lb;
    endtask

    task automatic add(input bit ld, input bit e, input bit u, input int lb,
                       input int xb, input int xg, input bit xw);
        vec_t v;
        v.ld = ld; v.e = e; v.u = u; v.lb = W'(lb);
        v.xbin = W'(xb); v.xgray = W'(xg); v.xwrap = xw;
        tbl.push_back(v);
    endtask

    initial begin
        int unsigned up_gray[17];
        logic [W-1:0] prev_gray;
        logic [15:0]  pg;
        vectors     = 0;
        miscompares = 0;

        // Reflected Gray table: the second half mirrors the first half with
        // the new top bit set.
        gtab[0] = 0;
        for (int unsigned k = 0; k < W; k++)
            for (int unsigned i = 0; i < (1 << k); i++)
                gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);

        up_gray = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1};

        // 17 up steps from reset, one past the wrap.
        for (int i = 0; i < 17; i++)
            add(0, 1, 1, 0, (i + 1) % 16, int'(up_gray[i]), i == 15);
        add(0, 1, 0, 0, 0, 0, 0);     // 1 -> 0, no wrap
        add(0, 1, 0, 0, 15, 8, 1);    // underflow
        add(0, 1, 0, 0, 14, 9, 0);
        add(1, 1, 1, 5, 5, 7, 0);     // load beats en
        add(0, 0, 1, 0, 5, 7, 0);     // hold x3
        add(0, 0, 0, 0, 5, 7, 0);
        add(0, 0, 1, 0, 5, 7, 0);
        add(1, 0, 0, 7, 7, 4, 0);
        add(0, 1, 1, 0, 8, 12, 0);    // alternate direction
        add(0, 1, 0, 0, 7, 4, 0);
        add(0, 1, 1, 0, 8, 12, 0);
        add(0, 1, 0, 0, 7, 4, 0);
        add(1, 1, 0, 0, 0, 0, 0);     // load with en=1, up=0 at 0: no wrap
        add(1, 1, 1, 15, 15, 8, 0);   // load of 15 with en=1, up=1: no wrap

        // Package helper against the independent table.
        for (int unsigned i = 0; i < MOD; i += 5) begin
            pg = bin2gray(16'(i));
            chk("pkg_bin2gray", pg, 16'(gtab[i]));
        end

        // Reset state, checked between clock edges.
        set_in(0, 0, 0, '0);
        rst_n = 1'b0;
        m_cnt = 0; m_wrap = 0;
        #2;
        chk("reset_bin", 16'(bin), 0);
        chk("reset_gray", 16'(gray), 0);
        chk("reset_wrap", 16'(wrap), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table.
        prev_gray = gray;
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].lb);
            step();
            chk($sformatf("tbl%0d_bin", i), 16'(bin), 16'(tbl[i].xbin));
            chk($sformatf("tbl%0d_gray", i), 16'(gray), 16'(tbl[i].xgray));
            chk($sformatf("tbl%0d_wrap", i), 16'(wrap), 16'(tbl[i].xwrap));
            if (tbl[i].e && !tbl[i].ld)
                chk($sformatf("tbl%0d_onebit", i), 16'($countones(gray ^ prev_gray)), 1);
            prev_gray = gray;
        end

        // Async reset mid-count: load 9, then drop rst_n between edges.
        set_in(1, 0, 0, 4'd9);
        step();
        chk("pre_rst_gray", 16'(gray), 13);
        set_in(0, 1, 1, '0);
        #3;
        rst_n = 1'b0;
        m_cnt = 0; m_wrap = 0;
        #1;
        chk("async_rst_bin", 16'(bin), 0);
        chk("async_rst_gray", 16'(gray), 0);
        chk("async_rst_wrap", 16'(wrap), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("held_rst_bin", 16'(bin), 0);
            chk("held_rst_gray", 16'(gray), 0);
        end
        rst_n = 1'b1;
        step();
        chk("release_bin", 16'(bin), 1);
        chk("release_gray", 16'(gray), 1);

        // Reset arriving while the wrap pulse is high clears it at once.
        set_in(1, 0, 0, 4'd15);
        step();
        set_in(0, 1, 1, '0);
        step();
        chk("wrap_before_rst", 16'(wrap), 1);
        #2;
        rst_n = 1'b0;
        m_cnt = 0; m_wrap = 0;
        #1;
        chk("wrap_async_clear", 16'(wrap), 0);
        set_in(0, 0, 0, '0);
        #3;
        rst_n = 1'b1;

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom), W'($urandom));
            step();
            chk("rnd_bin", 16'(bin), 16'(m_cnt));
            chk("rnd_gray", 16'(gray), 16'(gtab[m_cnt]));
            chk("rnd_wrap", 16'(wrap), 16'(m_wrap));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
